pc_sequencer: RTL
=================

# pc_sequencer

Program-counter sequencer for the single-cycle core. It owns the PC register and steps it on every fetch. On a taken branch it drives the 2-bit index into the branch-target lookup table and applies the returned 10-bit value as either an absolute target or a signed PC-relative offset. It also implements the Start/Done run handshake with the testbench and counts execution cycles.

## Interface
- PC_W, 10: PC width; equals lookup-table target width.
- IDX_W, 2: lookup-table index width; legal range 1..5.
- CNT_W, 16: cycle-counter width.

- Clk  in  1  clock; all state updates on its rising edge.
- Reset_n  in  1  reset, asynchronous, active-low.
- Start  in  1  level-sampled; begins or restarts a run from PC 0.
- Stall  in  1  freezes PC, state and the counter for the current cycle.
- Halt_req  in  1  current instruction is halt.
- Branch_en  in  1  current instruction is a taken branch.
- Branch_rel  in  1  1 = target is a two's-complement offset added to the branch PC; 0 = target is absolute.
- Branch_idx  in  IDX_W  lookup-table index from the instruction.
- Lut_target  in  PC_W  lookup-table output for Lut_addr, combinational.
- Lut_addr  out  IDX_W  registered index presented to the lookup table.
- PC  out  PC_W  current fetch address.
- Fetch_valid  out  1  PC holds a real instruction this cycle.
- Done  out  1  run complete; held until the next Start.
- Cycle_cnt  out  CNT_W  cycles spent in RUN or BRANCH during the current or last run.

## Operation
States: IDLE, RUN, BRANCH, HALTED (encoding free). Moore outputs:
- Fetch_valid = 1 only in RUN.
- Done = 1 only in HALTED.

IDLE:
- PC = 0.
- Start=1 → RUN. PC stays 0; Cycle_cnt cleared to 0.

RUN, when Stall=1: hold everything, and ignore Halt_req and Branch_en.

RUN, when Stall=0, decisions in priority order:
- Halt_req=1 → HALTED; PC held (points at the halt instruction).
- Else Branch_en=1: latch idx_r←Branch_idx, rel_r←Branch_rel, base_r←PC; PC held; → BRANCH.
- Else PC ← PC+1, modulo 2^PC_W.

BRANCH (one bubble cycle):
- Lut_addr = idx_r, and Lut_target is valid.
- Stall=0: PC ← rel_r ? (base_r + Lut_target) mod 2^PC_W : Lut_target; → RUN.
- Stall=1: hold.

HALTED:
- Start=1 → PC←0, Cycle_cnt←0 → RUN.

Start rules:
- Start is ignored in RUN and BRANCH.
- A Start held high across HALTED→RUN does not restart a second time; only the HALTED and IDLE states sample it.

Cycle_cnt:
- Increments by 1 on each non-stalled cycle in RUN or BRANCH.
- Saturates at all-ones.
- Frozen in HALTED and IDLE.

Lut_addr:
- Always driven from idx_r, including outside BRANCH.
- idx_r changes only on a branch accept.

Arithmetic: relative add uses PC_W-bit wrap with no overflow flag. Example: 0x3FF is −1.

## Timing
- Async reset (Reset_n low) sets: state IDLE, PC=0, idx_r=0, rel_r=0, base_r=0, Lut_addr=0, Fetch_valid=0, Done=0, Cycle_cnt=0.
- Reset asserted mid-run takes effect immediately, with no wait for a clock edge.
- Deassertion is expected synchronous to Clk from the environment.
- Sequential PC: +1 one edge after a non-stalled, non-branch, non-halt RUN cycle.
- Taken branch costs 2 cycles: the branch cycle, then the BRANCH bubble. The target PC is visible with Fetch_valid=1 on the edge after the bubble.
- Halt: Done rises on the edge after the halt cycle. PC stays at the halt address.
- Lookup-table path is combinational in the BRANCH cycle only; Lut_addr is stable for the whole cycle.
- Simultaneous Halt_req and Branch_en: halt wins; branch state is not latched.
- Stall in BRANCH extends the bubble; the target is not applied until the first Stall=0 cycle.

## Test plan
Lookup table populated {0:0x3FF, 1:0x003, 2:0x007, 3:0x001}.

1. **Reset and start:** reset, then Start pulse; no branches; Halt_req at PC=5 → PC 0..5 with Fetch_valid=1, Done=1 next edge, PC=5, Cycle_cnt=6.
2. **Branches:** at PC=5, Branch_en=1, Branch_rel=1, Branch_idx=0 → one bubble (Fetch_valid=0, Lut_addr=0), then PC=4. Separately, at PC=9, Branch_rel=0, Branch_idx=2 → PC=7 after the bubble.
3. **Wrap-around:** force run to PC=0x3FF (absolute branch idx0), next step → PC=0x000. Relative idx1 at PC=0x3FE → PC=0x001.
4. **Stall and priority:** Stall=1 for 3 cycles in RUN with Branch_en=1 → PC and Cycle_cnt frozen, no BRANCH entry. Stall=1 during BRANCH → bubble lengthens by 3, then correct target. Halt_req=1 with Branch_en=1 → HALTED, Lut_addr unchanged.
5. **Restart and mid-run reset:** Start in HALTED → PC=0, Done=0, Cycle_cnt=0, RUN. Start held during RUN → no restart. Reset_n low mid-BRANCH → outputs reset immediately, before the next Clk edge.
6. **Counter saturation:** CNT_W=4, run 20 cycles → Cycle_cnt=0xF held.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Signal bundle between the PC sequencer and its environment: run handshake,
// instruction decode controls, lookup-table port and PC/status outputs.
interface pc_sequencer_if #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned IDX_W = 2,
  parameter int unsigned CNT_W = 16
);
  logic             Start;
  logic             Stall;
  logic             Halt_req;
  logic             Branch_en;
  logic             Branch_rel;
  logic [IDX_W-1:0] Branch_idx;
  logic [PC_W-1:0]  Lut_target;
  logic [IDX_W-1:0] Lut_addr;
  logic [PC_W-1:0]  PC;
  logic             Fetch_valid;
  logic             Done;
  logic [CNT_W-1:0] Cycle_cnt;

  // Environment side: drives decode controls and answers the lookup table.
  modport master (
    output Start, Stall, Halt_req, Branch_en, Branch_rel, Branch_idx, Lut_target,
    input  Lut_addr, PC, Fetch_valid, Done, Cycle_cnt
  );

  // Sequencer side.
  modport slave (
    input  Start, Stall, Halt_req, Branch_en, Branch_rel, Branch_idx, Lut_target,
    output Lut_addr, PC, Fetch_valid, Done, Cycle_cnt
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, resolves taken branches through an
// external lookup table (absolute or PC-relative) and counts run cycles.
module pc_sequencer #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned IDX_W = 2,
  parameter int unsigned CNT_W = 16
) (
  input logic          Clk,
  input logic          Reset_n,
  pc_sequencer_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_BRANCH = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             rel_q, rel_d;
  logic [PC_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] cnt_sat_inc;
  logic [PC_W-1:0]  branch_target;

  // Counter sticks at all-ones instead of wrapping.
  assign cnt_sat_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign branch_target = rel_q ? (base_q + bus.Lut_target) : bus.Lut_target;

  // State register and all datapath flops.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      idx_q         <= '0;
      rel_q         <= 1'b0;
      base_q        <= '0;
      cnt_q         <= '0;
      fetch_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      idx_q         <= idx_d;
      rel_q         <= rel_d;
      base_q        <= base_d;
      cnt_q         <= cnt_d;
      fetch_valid_q <= fetch_valid_d;
      done_q        <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    idx_d   = idx_q;
    rel_d   = rel_q;
    base_d  = base_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        pc_d = '0;
        if (bus.Start) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!bus.Stall) begin
          cnt_d = cnt_sat_inc;
          if (bus.Halt_req) begin
            state_d = ST_HALTED;
          end else if (bus.Branch_en) begin
            idx_d   = bus.Branch_idx;
            rel_d   = bus.Branch_rel;
            base_d  = pc_q;
            state_d = ST_BRANCH;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      ST_BRANCH: begin
        // Lut_addr has shown idx_q since the branch edge, so Lut_target is settled.
        if (!bus.Stall) begin
          cnt_d   = cnt_sat_inc;
          pc_d    = branch_target;
          state_d = ST_RUN;
        end
      end
      ST_HALTED: begin
        if (bus.Start) begin
          pc_d    = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    fetch_valid_d = (state_d == ST_RUN);
    done_d        = (state_d == ST_HALTED);
  end

  assign bus.PC          = pc_q;
  assign bus.Lut_addr    = idx_q;
  assign bus.Fetch_valid = fetch_valid_q;
  assign bus.Done        = done_q;
  assign bus.Cycle_cnt   = cnt_q;

endmodule
